// File: rtl/morse_decoder_pkg.sv
// Shared definitions for the Morse decoder: FSM states, code field widths
// and the ASCII constants used for unknown characters and word spaces.
package morse_decoder_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    MARK  = 2'd1,
    SPACE = 2'd2,
    EMIT  = 2'd3
  } state_e;

  localparam int LEN_W    = 3;
  localparam int PAT_W    = 5;
  localparam int CODE_W   = LEN_W + PAT_W;
  localparam int MAX_ELEM = 5;
  localparam int CNT_W    = 8;

  localparam logic [7:0] ASCII_UNKNOWN = 8'h3F;
  localparam logic [7:0] ASCII_SPACE   = 8'h20;

  // Tick counter increment that sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] satInc(input logic [CNT_W-1:0] value);
    return (value == {CNT_W{1'b1}}) ? value : value + 1'b1;
  endfunction

endpackage

// File: rtl/morse_decoder_lut.sv
// Packed element code {len, pat} to ASCII table for ITU Morse A-Z and 0-9.
// The first element sits at pat[len-1]; dash = 1, dot = 0.
module morse_lut
  import morse_decoder_pkg::*;
(
  input  logic [CODE_W-1:0] code_i,
  output logic [7:0]        ascii_o
);

  always_comb begin
    ascii_o = ASCII_UNKNOWN;
    case (code_i)
      8'h20: ascii_o = "E";
      8'h21: ascii_o = "T";
      8'h40: ascii_o = "I";
      8'h41: ascii_o = "A";
      8'h42: ascii_o = "N";
      8'h43: ascii_o = "M";
      8'h60: ascii_o = "S";
      8'h61: ascii_o = "U";
      8'h62: ascii_o = "R";
      8'h63: ascii_o = "W";
      8'h64: ascii_o = "D";
      8'h65: ascii_o = "K";
      8'h66: ascii_o = "G";
      8'h67: ascii_o = "O";
      8'h80: ascii_o = "H";
      8'h81: ascii_o = "V";
      8'h82: ascii_o = "F";
      8'h84: ascii_o = "L";
      8'h86: ascii_o = "P";
      8'h87: ascii_o = "J";
      8'h88: ascii_o = "B";
      8'h89: ascii_o = "X";
      8'h8A: ascii_o = "C";
      8'h8B: ascii_o = "Y";
      8'h8C: ascii_o = "Z";
      8'h8D: ascii_o = "Q";
      8'hA0: ascii_o = "5";
      8'hA1: ascii_o = "4";
      8'hA3: ascii_o = "3";
      8'hA7: ascii_o = "2";
      8'hAF: ascii_o = "1";
      8'hB0: ascii_o = "6";
      8'hB8: ascii_o = "7";
      8'hBC: ascii_o = "8";
      8'hBE: ascii_o = "9";
      8'hBF: ascii_o = "0";
      default: ascii_o = ASCII_UNKNOWN;
    endcase
  end

endmodule

// File: rtl/morse_decoder.sv
// Morse keyer decoder: times key-down/key-up intervals in tick strobes,
// assembles dots and dashes into a code, and emits ASCII plus word spaces.
module morse_decoder
  import morse_decoder_pkg::*;
#(
  parameter int TPU = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic       key,
  output logic [7:0] code,
  output logic [7:0] ascii,
  output logic       ascii_valid,
  output logic       err
);

  localparam logic [CNT_W-1:0] DASH_MIN   = CNT_W'(2 * TPU);
  localparam logic [CNT_W-1:0] LETTER_GAP = CNT_W'(3 * TPU);
  localparam logic [CNT_W-1:0] WORD_GAP   = CNT_W'(4 * TPU);

  state_e             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [CNT_W-1:0]   cnt_d;
  logic [LEN_W-1:0]   len_q;
  logic [LEN_W-1:0]   len_d;
  logic [PAT_W-1:0]   pat_q;
  logic [PAT_W-1:0]   pat_d;
  logic               ovf_q;
  logic               wordArmed_q;
  logic [CODE_W-1:0]  code_q;
  logic [7:0]         ascii_q;
  logic               asciiValid_q;
  logic               err_q;

  logic               isDash;
  logic               canShift;
  logic               isUnknown;
  logic [7:0]         lutAscii;

  morse_lut u_lut (
    .code_i  ({len_q, pat_q}),
    .ascii_o (lutAscii)
  );

  // Classification uses the registered count, so a tick in the release cycle is ignored.
  assign cnt_d     = tick ? satInc(cnt_q) : cnt_q;
  assign isDash    = (cnt_q >= DASH_MIN);
  assign canShift  = (len_q < LEN_W'(MAX_ELEM));
  assign pat_d     = {pat_q[PAT_W-2:0], isDash};
  assign len_d     = len_q + 1'b1;
  assign isUnknown = ovf_q || (lutAscii == ASCII_UNKNOWN);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      len_q        <= '0;
      pat_q        <= '0;
      ovf_q        <= 1'b0;
      wordArmed_q  <= 1'b0;
      code_q       <= '0;
      ascii_q      <= '0;
      asciiValid_q <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      asciiValid_q <= 1'b0;
      err_q        <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (key) begin
            state_q     <= MARK;
            cnt_q       <= '0;
            wordArmed_q <= 1'b0;
          end else if (wordArmed_q) begin
            if (cnt_q == WORD_GAP) begin
              ascii_q      <= ASCII_SPACE;
              asciiValid_q <= 1'b1;
              wordArmed_q  <= 1'b0;
            end else begin
              cnt_q <= cnt_d;
            end
          end
        end

        // Elements beyond MAX_ELEM are dropped but remembered as an overflow.
        MARK: begin
          if (!key) begin
            if (canShift) begin
              pat_q <= pat_d;
              len_q <= len_d;
            end else begin
              ovf_q <= 1'b1;
            end
            state_q <= SPACE;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_d;
          end
        end

        SPACE: begin
          if (key) begin
            state_q <= MARK;
            cnt_q   <= '0;
          end else if (cnt_q == LETTER_GAP) begin
            state_q <= EMIT;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_d;
          end
        end

        EMIT: begin
          code_q       <= {len_q, pat_q};
          ascii_q      <= isUnknown ? ASCII_UNKNOWN : lutAscii;
          err_q        <= isUnknown;
          asciiValid_q <= 1'b1;
          len_q        <= '0;
          pat_q        <= '0;
          ovf_q        <= 1'b0;
          wordArmed_q  <= 1'b1;
          cnt_q        <= '0;
          state_q      <= IDLE;
        end

        default: begin
          state_q <= IDLE;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  assign code        = code_q;
  assign ascii       = ascii_q;
  assign ascii_valid = asciiValid_q;
  assign err         = err_q;

endmodule

// File: tb/tb_morse_decoder.sv
// Self-checking bench for morse_decoder: directed keying scenarios plus random
// characters, checked against a string-based Morse reference model.
module tb_morse_decoder;

  localparam int TPU  = 4;
  localparam int SLOT = 3;

  logic       clk = 1'b0;
  logic       reset;
  logic       tick;
  logic       key;
  logic [7:0] code;
  logic [7:0] ascii;
  logic       ascii_valid;
  logic       err;

  int testsRun    = 0;
  int testsFailed = 0;
  int cyc         = 0;
  int lastTickCyc = 0;
  int doublePulse = 0;
  int strayErr    = 0;
  logic prevValid = 1'b0;

  logic [16:0] expQ[$];
  logic [16:0] obsQ[$];
  int          obsCyc[$];
  int          stimPress[$];
  int          stimGap[$];
  logic [7:0]  modelCode;

  string charTab = "ABCDEFGHIJKLMNOPQRSTUVWXYZ0123456789";
  string morseTab[36] = '{
    ".-", "-...", "-.-.", "-..", ".", "..-.", "--.", "....", "..", ".---",
    "-.-", ".-..", "--", "-.", "---", ".--.", "--.-", ".-.", "...", "-",
    "..-", "...-", ".--", "-..-", "-.--", "--..",
    "-----", ".----", "..---", "...--", "....-", ".....", "-....", "--...",
    "---..", "----."
  };

  morse_decoder #(.TPU(TPU)) dut (
    .clk         (clk),
    .reset       (reset),
    .tick        (tick),
    .key         (key),
    .code        (code),
    .ascii       (ascii),
    .ascii_valid (ascii_valid),
    .err         (err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor samples on the falling edge and records every emission.
  always @(negedge clk) begin
    if (ascii_valid) begin
      obsQ.push_back({err, code, ascii});
      obsCyc.push_back(cyc);
    end
    if (ascii_valid && prevValid) doublePulse++;
    if (err && !ascii_valid) strayErr++;
    prevValid = ascii_valid;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit expired");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    testsRun++;
    if (observed !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Each tick slot is SLOT clocks: key changes on the first, tick on the last.
  task automatic applyStimulus(input logic keyVal, input int nTicks);
    for (int s = 0; s < nTicks; s++) begin
      for (int c = 0; c < SLOT; c++) begin
        @(posedge clk);
        #1;
        if (c == 0) key = keyVal;
        tick = (c == SLOT - 1);
        if (tick) lastTickCyc = cyc;
      end
    end
  endtask

  task automatic idleClocks(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      tick = 1'b0;
    end
  endtask

  function automatic logic [7:0] modelLookup(input string pat);
    for (int k = 0; k < 36; k++)
      if (morseTab[k] == pat) return charTab[k];
    return 8'h3F;
  endfunction

  // Reference: turn press/gap durations (in Morse ticks) into expected emissions.
  task automatic buildExpected();
    string      pat;
    int         n;
    int         p;
    logic [7:0] asc;
    logic [7:0] code8;
    pat = "";
    for (int i = 0; i < stimPress.size(); i++) begin
      if (stimPress[i] >= 2 * TPU) pat = {pat, "-"};
      else pat = {pat, "."};
      if (stimGap[i] >= 3 * TPU) begin
        n = (pat.len() > 5) ? 5 : pat.len();
        p = 0;
        for (int j = 0; j < n; j++) p = p * 2 + ((pat[j] == "-") ? 1 : 0);
        code8 = {3'(n), 5'(p)};
        asc = modelLookup(pat);
        expQ.push_back({(asc == 8'h3F), code8, asc});
        modelCode = code8;
        if (stimGap[i] >= 7 * TPU) expQ.push_back({1'b0, modelCode, 8'h20});
        pat = "";
      end
    end
  endtask

  task automatic runScenario(input string name, input int extraIdle);
    obsQ.delete();
    obsCyc.delete();
    expQ.delete();
    buildExpected();
    for (int i = 0; i < stimPress.size(); i++) begin
      applyStimulus(1'b1, stimPress[i]);
      applyStimulus(1'b0, stimGap[i]);
    end
    applyStimulus(1'b0, extraIdle);
    idleClocks(6);
    checkOutput({name, ".count"}, obsQ.size(), expQ.size());
    for (int i = 0; i < expQ.size() && i < obsQ.size(); i++)
      checkOutput($sformatf("%s.emit%0d", name, i), obsQ[i], expQ[i]);
    stimPress.delete();
    stimGap.delete();
  endtask

  task automatic addElem(input int press, input int gap);
    stimPress.push_back(press);
    stimGap.push_back(gap);
  endtask

  // Random characters: legal gaps stay clear of the exact letter/word thresholds.
  task automatic genRandomChars(input int nChars);
    for (int c = 0; c < nChars; c++) begin
      string pat;
      int    nElem;
      int    last;
      if ($urandom_range(0, 9) == 0) begin
        pat = "";
        nElem = $urandom_range(6, 7);
        for (int e = 0; e < nElem; e++) begin
          if ($urandom_range(0, 1) == 1) pat = {pat, "-"};
          else pat = {pat, "."};
        end
      end else begin
        pat = morseTab[$urandom_range(0, 35)];
      end
      for (int e = 0; e < pat.len(); e++) begin
        if (pat[e] == "-") stimPress.push_back($urandom_range(2 * TPU, 4 * TPU));
        else stimPress.push_back($urandom_range(1, 2 * TPU - 1));
        stimGap.push_back($urandom_range(1, 3 * TPU - 2));
      end
      last = stimGap.size() - 1;
      if ($urandom_range(0, 3) == 0) stimGap[last] = $urandom_range(7 * TPU + 1, 7 * TPU + 8);
      else stimGap[last] = $urandom_range(3 * TPU + 1, 7 * TPU - 1);
    end
  endtask

  initial begin
    reset = 1'b1;
    key   = 1'b0;
    tick  = 1'b0;
    modelCode = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst.code", code, 8'h00);
    checkOutput("rst.ascii", ascii, 8'h00);
    checkOutput("rst.valid", ascii_valid, 1'b0);
    checkOutput("rst.err", err, 1'b0);
    reset = 1'b0;
    idleClocks(2);

    addElem(4, 12);
    runScenario("letterE", 0);
    checkOutput("letterE.latency", (obsCyc.size() > 0) ? obsCyc[0] : -1, lastTickCyc + 3);

    addElem(4, 4);
    addElem(12, 12);
    runScenario("letterA", 0);

    addElem(7, 14);
    addElem(8, 14);
    runScenario("dotDashEdge", 0);

    addElem(4, 2);
    addElem(4, 2);
    addElem(4, 28);
    runScenario("wordSpace", 40);

    for (int i = 0; i < 5; i++) addElem(4, 2);
    addElem(4, 14);
    addElem(4, 2);
    addElem(12, 14);
    runScenario("overflow", 0);

    obsQ.delete();
    applyStimulus(1'b1, 6);
    @(posedge clk);
    #1;
    tick  = 1'b0;
    reset = 1'b1;
    @(posedge clk);
    #1;
    key = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("rstMark.code", code, 8'h00);
    checkOutput("rstMark.ascii", ascii, 8'h00);
    checkOutput("rstMark.valid", ascii_valid, 1'b0);
    checkOutput("rstMark.err", err, 1'b0);
    reset = 1'b0;
    modelCode = 8'h00;
    applyStimulus(1'b0, 40);
    idleClocks(6);
    checkOutput("rstMark.pulses", obsQ.size(), 0);
    checkOutput("rstMark.codeHeld", code, 8'h00);
    checkOutput("rstMark.asciiHeld", ascii, 8'h00);

    @(posedge clk);
    #1;
    reset = 1'b1;
    key   = 1'b1;
    tick  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    addElem(4, 14);
    runScenario("rstHeld", 0);

    genRandomChars(25);
    runScenario("random", 0);

    checkOutput("pulseWidth", doublePulse, 0);
    checkOutput("errAlone", strayErr, 0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/morse_decoder.md
MORSE_DECODER -- requirements
Module: morse_decoder

Interface
REQ-001 The block SHALL have parameter TPU, default 4, meaning tick strobes per Morse time unit; legal range 1..32.
REQ-002 The block SHALL have port clk  input  1  the single system clock.
REQ-003 The block SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 The block SHALL have port tick  input  1  one-cycle timing strobe; TPU strobes make one Morse unit.
REQ-005 The block SHALL have port key  input  1  already synchronized and debounced keyer level; 1 = key down.
REQ-006 The block SHALL have port code  output  8  last packed element code, {len[2:0], pat[4:0]}.
REQ-007 The block SHALL have port ascii  output  8  last decoded character.
REQ-008 The block SHALL have port ascii_valid  output  1  one-cycle strobe marking a new ascii value.
REQ-009 The block SHALL have port err  output  1  one-cycle strobe marking an overlong or unknown character, coincident with ascii_valid.

Function
REQ-010 The FSM SHALL have states IDLE, MARK, SPACE and EMIT, with an 8-bit saturating tick counter cnt that is cleared on every state entry.
REQ-011 IDLE SHALL move to MARK when key=1.
REQ-012 MARK SHALL add 1 to cnt on each tick.
REQ-013 When key=0 in MARK, the element SHALL be a dot if cnt < 2*TPU and a dash otherwise; the FSM then moves to SPACE.
REQ-014 The classification SHALL use the registered cnt; a tick in the release cycle is not counted.
REQ-015 Each element SHALL shift into pat at bit 0 (dash=1, dot=0) and increment len, so the first element sits at pat[len-1].
REQ-016 A sixth or later element SHALL NOT be shifted in; it SHALL set an internal overflow flag, and len SHALL stay 5.
REQ-017 SPACE SHALL add 1 to cnt on each tick.
REQ-018 In SPACE, key=1 SHALL move the FSM to MARK.
REQ-019 In SPACE, cnt == 3*TPU SHALL move the FSM to EMIT.
REQ-020 If key=1 in the same cycle that cnt == 3*TPU, key SHALL take priority and the FSM goes to MARK.
REQ-021 EMIT SHALL last one cycle.
REQ-022 In EMIT, code SHALL be loaded with {len,pat}, ascii with the lookup result, and ascii_valid pulsed.
REQ-023 ascii_valid SHALL be high exactly one cycle, two clocks after the edge at which cnt reaches 3*TPU.
REQ-024 When the overflow flag is set or the code is not in the table, ascii SHALL be 0x3F and err SHALL pulse with ascii_valid.
REQ-025 After EMIT, len, pat and the overflow flag SHALL be cleared, word_armed SHALL be set, and the FSM returns to IDLE.
REQ-026 In IDLE with word_armed=1, cnt SHALL count ticks.
REQ-027 When that IDLE count reaches 4*TPU (7 units after the last release), the block SHALL emit ascii=0x20 with ascii_valid and clear word_armed.
REQ-028 The 0x20 word space SHALL be emitted at most once per silence; code is unchanged by it.
REQ-029 key=1 in IDLE SHALL clear word_armed without emitting.
REQ-030 code and ascii SHALL hold their values between emissions.
REQ-031 The lookup table SHALL cover A-Z and 0-9 in ITU Morse, for example A=0x41, E=0x20, T=0x21, S=0x60, O=0x67, 0=0xBF.

Reset
REQ-032 While reset=1, the block SHALL force state IDLE and clear cnt, len, pat, the overflow flag and word_armed.
REQ-033 While reset=1, code, ascii, ascii_valid and err SHALL all be 0.
REQ-034 Reset in any state, including mid-MARK or mid-SPACE, SHALL discard the partial character with no emission.
REQ-035 After reset is released with key still held, the block SHALL enter MARK on the first cycle, counting from 0.

Structure
REQ-036 A shared package SHALL hold the FSM state encoding, the code field widths (LEN_W=3, PAT_W=5), MAX_ELEM=5, and the constants ASCII_UNKNOWN=0x3F and ASCII_SPACE=0x20.
REQ-037 The block SHALL contain one sub-module, morse_lut: a combinational 8-bit code to 8-bit ASCII case table that returns 0x3F for unmapped codes.

Verification (TPU=4)
REQ-038 Bench SHALL cover: key down 4 ticks, release, idle 12 ticks -> code=0x20, ascii=0x45, one ascii_valid pulse, err=0.
REQ-039 Bench SHALL cover: dot of 4 ticks, gap of 4 ticks, dash of 12 ticks, gap of 12 ticks -> code=0x41, ascii=0x41.
REQ-040 Bench SHALL cover: dot timing boundary, press 7 ticks -> dot; press 8 ticks -> dash.
REQ-041 Bench SHALL cover: three dots, then 28 idle ticks -> ascii=0x53, then exactly one ascii=0x20 pulse, then no further pulses.
REQ-042 Bench SHALL cover: six dots, then a letter gap -> ascii=0x3F with err pulse; the next character decodes normally.
REQ-043 Bench SHALL cover: reset asserted mid-MARK after 6 ticks, key then released -> all outputs 0 and no ascii_valid for at least 40 ticks.
